// File: rtl/compress_pack_ctrl.sv
// rtl/compress_pack_ctrl.sv - float32-to-16-bit code frame controller with pair packing; COMPRESS_SAT_EN clamps out-of-range codes
module compress_f32_code (
    input  logic [31:0] i_data,
    output logic [15:0] o_code,
    output logic        o_oor
);
    logic [7:0]  w_exp;
    logic [7:0]  w_shift;
    logic [23:0] w_mant;
    logic [14:0] w_frac;

    always_comb begin
        w_exp   = i_data[30:23];
        // Wraps modulo 256, so any exponent above 127 shifts the mantissa out entirely
        w_shift = 8'd127 - w_exp;
        w_mant  = {1'b1, i_data[22:0]};
        w_frac  = 15'((w_mant >> w_shift) >> 8);
        o_oor   = (w_exp >= 8'd127);
`ifdef COMPRESS_SAT_EN
        if (o_oor) begin
            w_frac = 15'h7FFF;
        end
`endif
        o_code  = {i_data[31], w_frac};
    end
endmodule

module compress_pack_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic [LEN_W-1:0] range_cnt
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOW   = 3'd1,
        S_HIGH  = 3'd2,
        S_PAD   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_out_valid;
    logic             r_out_last;
    logic [31:0]      r_out_data;
    logic [15:0]      r_low;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_range;

    logic [15:0]      w_code;
    logic             w_oor;
    logic             w_out_fire;
    logic             w_out_free;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last_in;

    compress_f32_code u_code (
        .i_data (in_data),
        .o_code (w_code),
        .o_oor  (w_oor)
    );

    always_comb begin
        w_out_fire = r_out_valid && out_ready;
        w_out_free = !r_out_valid || out_ready;
        // The low half only fills r_low, so it may be taken while the output word is still waiting
        w_in_ready = (r_state == S_LOW) || ((r_state == S_HIGH) && w_out_free);
        w_accept   = in_valid && w_in_ready;
        w_last_in  = (r_remaining == LEN_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_low       <= 16'h0000;
            r_remaining <= '0;
            r_range     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_oor && (r_range != '1)) begin
                r_range <= r_range + LEN_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_range <= '0;
                        if (cfg_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_remaining <= cfg_len;
                            r_busy      <= 1'b1;
                            r_state     <= S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (w_accept) begin
                        r_low       <= w_code;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_state     <= w_last_in ? S_PAD : S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_accept) begin
                        r_out_data  <= {w_code, r_low};
                        r_out_valid <= 1'b1;
                        r_out_last  <= w_last_in;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_state     <= w_last_in ? S_DRAIN : S_LOW;
                    end
                end
                S_PAD: begin
                    if (w_out_free) begin
                        r_out_data  <= {16'h0000, r_low};
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b1;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign range_cnt = r_range;
endmodule
